// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared key codes, PS/2 prefix bytes and FSM state types
package dino_pkg;

  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_ENTER = 9'h05A;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    D_BASE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_BITS
  } rx_state_e;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                          is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 pin conditioning and frame receiver with watchdog
// Odd-parity acceptance is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx
  import dino_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] CNT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WD_MAX  = TW'(TIMEOUT_CYC - 1);

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
  logic          fall_q, fall_d;

  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_ok;

  // A filtered line only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_filt_d  = clk_filt_q;
    clk_cnt_d   = clk_cnt_q;
    data_filt_d = data_filt_q;
    data_cnt_d  = data_cnt_q;
    if (clk_s2_q == clk_filt_q) begin
      clk_cnt_d = '0;
    end else if (clk_cnt_q == CNT_MAX) begin
      clk_filt_d = clk_s2_q;
      clk_cnt_d  = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
    if (data_s2_q == data_filt_q) begin
      data_cnt_d = '0;
    end else if (data_cnt_q == CNT_MAX) begin
      data_filt_d = data_s2_q;
      data_cnt_d  = '0;
    end else begin
      data_cnt_d = data_cnt_q + 1'b1;
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = data_filt_q & (^shift_q);
`else
  assign frame_ok = data_filt_q;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    wdog_d       = wdog_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    case (state_q)
      RX_IDLE: begin
        wdog_d = '0;
        if (fall_q && !data_filt_q) begin
          state_d   = RX_BITS;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      RX_BITS: begin
        if (fall_q) begin
          wdog_d = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = RX_IDLE;
            if (frame_ok) begin
              byte_valid_d = 1'b1;
              byte_d       = shift_q[7:0];
            end
          end else begin
            shift_d   = {data_filt_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (wdog_q == WD_MAX) begin
          state_d   = RX_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      clk_filt_q   <= 1'b1;
      data_filt_q  <= 1'b1;
      clk_cnt_q    <= '0;
      data_cnt_q   <= '0;
      fall_q       <= 1'b0;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wdog_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
    end else begin
      clk_s1_q     <= ps2_clk_i;
      clk_s2_q     <= clk_s1_q;
      data_s1_q    <= ps2_data_i;
      data_s2_q    <= data_s1_q;
      clk_filt_q   <= clk_filt_d;
      data_filt_q  <= data_filt_d;
      clk_cnt_q    <= clk_cnt_d;
      data_cnt_q   <= data_cnt_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wdog_q       <= wdog_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - Set-2 make/break decoder maintaining a 512-entry pressed-key map
// Parity checking in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_tracker
  import dino_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid
);

  logic       rx_valid;
  logic [7:0] rx_byte;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i       (pclk),
    .rst_ni      (rst_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte)
  );

  dec_state_e   dec_q, dec_d;
  logic [511:0] key_down_q, key_down_d;
  logic [8:0]   last_q, last_d;
  logic         valid_q, valid_d;
  logic         ext, brk;
  logic [8:0]   code;

  assign ext  = (dec_q == D_EXT) || (dec_q == D_EXT_BRK);
  assign brk  = (dec_q == D_BRK) || (dec_q == D_EXT_BRK);
  assign code = {ext, rx_byte};

  // Prefixes accumulate; the first non-prefix byte consumes them and resets to D_BASE.
  always_comb begin
    dec_d      = dec_q;
    key_down_d = key_down_q;
    last_d     = last_q;
    valid_d    = 1'b0;
    if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        dec_d = brk ? D_EXT_BRK : D_EXT;
      end else if (rx_byte == PS2_BRK) begin
        dec_d = ext ? D_EXT_BRK : D_BRK;
      end else if (is_discard(rx_byte)) begin
        dec_d = D_BASE;
      end else begin
        key_down_d[code] = ~brk;
        last_d           = code;
        valid_d          = 1'b1;
        dec_d            = D_BASE;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q      <= D_BASE;
      key_down_q <= '0;
      last_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      key_down_q <= key_down_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_q;
  assign key_valid   = valid_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed frame sequences with hand-computed key map expectations
module tb_ps2_key_tracker;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 20;

  logic         pclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int exp_pulses = 0;
  logic [511:0] exp_kd = '0;

  ps2_key_tracker #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (key_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_parity);
    send_bit(1'b1);
    wait_cyc(2 * HALF);
  endtask

  task automatic key_bit(input logic [8:0] code, input logic v);
    exp_kd[code] = v;
  endtask

  initial begin
    wait_cyc(3);
    check("reset_key_down", key_down, '0);
    check("reset_last_change", last_change, '0);
    check("reset_key_valid", key_valid, '0);
    rst_n = 1'b1;
    wait_cyc(5);

    send_byte(8'h29, 1'b0);
    exp_pulses++; key_bit(9'h029, 1'b1);
    check("space_make_pulses", pulses, exp_pulses);
    check("space_make_last", last_change, 9'h029);
    check("space_make_map", key_down, exp_kd);

    send_byte(8'hF0, 1'b0);
    check("brk_prefix_no_pulse", pulses, exp_pulses);
    send_byte(8'h29, 1'b0);
    exp_pulses++; key_bit(9'h029, 1'b0);
    check("space_break_pulses", pulses, exp_pulses);
    check("space_break_map", key_down, exp_kd);
    check("space_break_last", last_change, 9'h029);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    exp_pulses++; key_bit(9'h175, 1'b1);
    check("up_make_map", key_down, exp_kd);
    check("up_make_last", last_change, 9'h175);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    exp_pulses++; key_bit(9'h175, 1'b0);
    check("up_break_map", key_down, exp_kd);
    check("up_break_last", last_change, 9'h175);
    check("up_pulses", pulses, exp_pulses);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("discard_no_pulse", pulses, exp_pulses);
    send_byte(8'h29, 1'b0);
    exp_pulses++; key_bit(9'h029, 1'b1);
    check("discard_clears_ext_last", last_change, 9'h029);
    check("discard_clears_ext_map", key_down, exp_kd);

    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    exp_pulses += 2; key_bit(9'h01C, 1'b1);
    check("typematic_pulses", pulses, exp_pulses);
    check("typematic_map", key_down, exp_kd);
    check("typematic_last", last_change, 9'h01C);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    exp_pulses++;
    check("unmatched_break_pulses", pulses, exp_pulses);
    check("unmatched_break_map", key_down, exp_kd);
    check("unmatched_break_last", last_change, 9'h05A);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    exp_pulses += 2; key_bit(9'h029, 1'b0); key_bit(9'h01C, 1'b0);
    check("clear_all_map", key_down, exp_kd);

    send_byte(8'h29, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("bad_parity_last", last_change, 9'h01C);
`else
    exp_pulses++; key_bit(9'h029, 1'b1);
    check("bad_parity_last", last_change, 9'h029);
`endif
    check("bad_parity_pulses", pulses, exp_pulses);
    check("bad_parity_map", key_down, exp_kd);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    exp_pulses++;
    check("pre_wdog_last", last_change, 9'h05A);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_cyc(TIMEOUT_CYC + 10);
    send_byte(8'h1C, 1'b0);
    exp_pulses++; key_bit(9'h01C, 1'b1);
    check("wdog_pulses", pulses, exp_pulses);
    check("wdog_last", last_change, 9'h01C);
    check("wdog_map", key_down, exp_kd);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    rst_n = 1'b0;
    wait_cyc(3);
    exp_kd = '0;
    check("midreset_map", key_down, exp_kd);
    check("midreset_last", last_change, 9'h000);
    check("midreset_valid", key_valid, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);
    send_byte(8'h29, 1'b0);
    exp_pulses++; key_bit(9'h029, 1'b1);
    check("post_reset_last", last_change, 9'h029);
    check("post_reset_map", key_down, exp_kd);
    check("total_pulses", pulses, exp_pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
